// File: rtl/mmu_bus_responder_pkg.sv
// mmu_bus_responder_pkg: shared constants, FSM state type, request struct and
// device-register read mux for the MMU bus responder.
package mmu_bus_responder_pkg;

  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  localparam logic [15:0] BUS_SEL_RAM = 16'h0001;
  localparam logic [15:0] BUS_SEL_DEV = 16'h0002;

  typedef enum logic [1:0] {
    BRSP_IDLE    = 2'd0,
    BRSP_WAIT    = 2'd1,
    BRSP_ACK     = 2'd2,
    BRSP_RECOVER = 2'd3
  } brsp_state_e;

  localparam logic [1:0] DEV_REG_ID      = 2'd0;
  localparam logic [1:0] DEV_REG_SCRATCH = 2'd1;
  localparam logic [1:0] DEV_REG_COUNT   = 2'd2;
  localparam logic [1:0] DEV_REG_STATUS  = 2'd3;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] sel;
  } bus_req_t;

  function automatic logic [31:0] dev_read(input logic [1:0]  idx,
                                           input logic [31:0] id,
                                           input logic [31:0] scratch,
                                           input logic [31:0] cnt,
                                           input logic        err);
    logic [31:0] v;
    v = ZERO_WORD;
    case (idx)
      DEV_REG_ID:      v = id;
      DEV_REG_SCRATCH: v = scratch;
      DEV_REG_COUNT:   v = cnt;
      DEV_REG_STATUS:  v = {31'b0, err};
      default:         v = ZERO_WORD;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/bus_word_ram.sv
// bus_word_ram: single-port synchronous 2**AW x 32 word RAM, registered read.
// Ports: clk; en (access strobe); we (1 = write); addr (word index);
//        wdata (write word); rdata (read word, updated only on read accesses).
module bus_word_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // rdata only moves on a read, so it holds the last read word across writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mmu_bus_responder.sv
// mmu_bus_responder: responder end of the MMU memory bus. Captures one request
// in IDLE, waits WAIT_CYCLES, acks for one cycle with registered read data,
// then spends one RECOVER cycle before accepting the next request.
// Ports: clk, rst (async, active high); bus_ce_i/bus_we_i/bus_addr_i/
//        bus_data_i/bus_select_i (request); bus_data_o (read data, held
//        between acks); bus_ack_o (one-cycle completion); err_o (sticky
//        unmapped-access flag).
module mmu_bus_responder
  import mmu_bus_responder_pkg::*;
#(
  parameter int          RAM_AW      = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] DEV_ID      = 32'h4D4D5531
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_ce_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_i,
  input  logic [31:0] bus_data_i,
  input  logic [15:0] bus_select_i,
  output logic [31:0] bus_data_o,
  output logic        bus_ack_o,
  output logic        err_o
);

  brsp_state_e state;
  bus_req_t    req_q;
  bus_req_t    cur;
  logic [3:0]  wait_cnt;
  logic [31:0] scratch;
  logic [31:0] acc_cnt;
  logic        err_q;
  logic [31:0] data_q;
  logic        ram_src;   // bus_data_o sourced from the RAM read register
  logic [31:0] ram_rdata;
  logic        req_valid;
  logic        to_ack;
  logic        ram_rd;
  logic        ram_wr;
  logic        unused_addr;

  assign req_valid = (bus_ce_i == CHIP_ENABLE) && (bus_select_i != 16'h0000);

  // The transaction in flight: live bus inputs while IDLE (for the
  // zero-wait case, where capture and pre-ack cycle coincide), else latched.
  always_comb begin
    cur = req_q;
    if (state == BRSP_IDLE) begin
      cur.we   = bus_we_i;
      cur.addr = bus_addr_i;
      cur.data = bus_data_i;
      cur.sel  = bus_select_i;
    end
  end

  // High in the cycle before ACK.
  assign to_ack = ((state == BRSP_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                  ((state == BRSP_WAIT) && (wait_cnt == 4'd1));

  // RAM read is launched one cycle early so its registered output is valid
  // during the ack cycle; writes commit on the edge that leaves ACK.
  assign ram_rd = to_ack && (cur.we != WRITE_ENABLE) && (cur.sel == BUS_SEL_RAM);
  assign ram_wr = (state == BRSP_ACK) && (req_q.we == WRITE_ENABLE) &&
                  (req_q.sel == BUS_SEL_RAM);

  bus_word_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .en    (ram_rd || ram_wr),
    .we    (ram_wr),
    .addr  (cur.addr[RAM_AW+1:2]),
    .wdata (req_q.data),
    .rdata (ram_rdata)
  );

  assign unused_addr = ^cur.addr;

  assign bus_data_o = ram_src ? ram_rdata : data_q;
  assign err_o      = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state     <= BRSP_IDLE;
      req_q     <= '0;
      wait_cnt  <= 4'd0;
      scratch   <= ZERO_WORD;
      acc_cnt   <= ZERO_WORD;
      err_q     <= 1'b0;
      data_q    <= ZERO_WORD;
      ram_src   <= 1'b0;
      bus_ack_o <= 1'b0;
    end else begin
      bus_ack_o <= to_ack;

      // Read data register loads on entry to ACK; write acks leave it alone.
      if (to_ack && (cur.we != WRITE_ENABLE)) begin
        ram_src <= (cur.sel == BUS_SEL_RAM);
        data_q  <= (cur.sel == BUS_SEL_DEV) ?
                   dev_read(cur.addr[3:2], DEV_ID, scratch, acc_cnt, err_q) :
                   ZERO_WORD;
      end

      case (state)
        BRSP_IDLE: begin
          if (req_valid) begin
            req_q    <= cur;
            wait_cnt <= 4'(WAIT_CYCLES);
            state    <= (WAIT_CYCLES == 0) ? BRSP_ACK : BRSP_WAIT;
          end
        end
        BRSP_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= BRSP_ACK;
        end
        BRSP_ACK: begin
          state   <= BRSP_RECOVER;
          acc_cnt <= acc_cnt + 32'd1;
          if (req_q.sel == BUS_SEL_DEV) begin
            if (req_q.we == WRITE_ENABLE) begin
              case (req_q.addr[3:2])
                DEV_REG_SCRATCH: scratch <= req_q.data;
                DEV_REG_COUNT:   acc_cnt <= ZERO_WORD;  // clear beats increment
                DEV_REG_STATUS:  if (req_q.data[0]) err_q <= 1'b0;
                default: ;                              // ID is read-only
              endcase
            end
          end else if (req_q.sel != BUS_SEL_RAM) begin
            err_q <= 1'b1;
          end
        end
        BRSP_RECOVER: state <= BRSP_IDLE;
        default:      state <= BRSP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_bus_responder.sv
module tb_mmu_bus_responder;

  localparam logic [31:0] DEV_ID = 32'h4D4D5531;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT with one wait state
  logic        ce, we;
  logic [31:0] addr, wdata, rdata;
  logic [15:0] sel;
  logic        ack, err;
  // DUT with zero wait states
  logic        ce0, we0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [15:0] sel0;
  logic        ack0, err0;

  mmu_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(1), .DEV_ID(DEV_ID)) u_dut (
    .clk(clk), .rst(rst), .bus_ce_i(ce), .bus_we_i(we), .bus_addr_i(addr),
    .bus_data_i(wdata), .bus_select_i(sel), .bus_data_o(rdata),
    .bus_ack_o(ack), .err_o(err));

  mmu_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(0), .DEV_ID(DEV_ID)) u_w0 (
    .clk(clk), .rst(rst), .bus_ce_i(ce0), .bus_we_i(we0), .bus_addr_i(addr0),
    .bus_data_i(wdata0), .bus_select_i(sel0), .bus_data_o(rdata0),
    .bus_ack_o(ack0), .err_o(err0));

  int n_checks = 0;
  int n_err    = 0;

  // reference model
  logic [31:0] m_mem [1024];
  logic [31:0] m_scratch = 0, m_cnt = 0, m_last = 0;
  logic        m_err = 0;
  logic [31:0] written [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the 1-wait DUT; entered and left at a negedge with the DUT idle.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [15:0] s);
    logic [31:0] exp_rd;
    int k;
    int idx;
    idx = int'((a >> 2) % 1024);
    exp_rd = m_last;
    if (!w) begin
      if (s == 16'h0001) exp_rd = m_mem[idx];
      else if (s == 16'h0002) begin
        case (a[3:2])
          2'd0: exp_rd = DEV_ID;
          2'd1: exp_rd = m_scratch;
          2'd2: exp_rd = m_cnt;
          default: exp_rd = {31'b0, m_err};
        endcase
      end else exp_rd = 32'h0;
    end
    ce = 1; we = w; addr = a; wdata = d; sel = s;
    @(posedge clk);
    #1;
    ce = 0; we = $urandom_range(0, 1); addr = $urandom; wdata = $urandom; sel = 16'($urandom);
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack) break;
    end
    chk("ack_latency", 32'(k), 32'd2);
    chk("bus_data", rdata, exp_rd);
    // apply effects of the completed access
    if (s == 16'h0001) begin
      if (w) begin m_mem[idx] = d; written.push_back(a); end
    end else if (s == 16'h0002) begin
      if (w) begin
        if (a[3:2] == 2'd1) m_scratch = d;
        if (a[3:2] == 2'd3 && d[0]) m_err = 0;
      end
    end else m_err = 1;
    if (w && s == 16'h0002 && a[3:2] == 2'd2) m_cnt = 0;
    else m_cnt = m_cnt + 1;
    if (!w) m_last = exp_rd;
    @(negedge clk);
    chk("recover_no_ack", 32'(ack), 32'd0);
    chk("err_o", 32'(err), 32'(m_err));
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] s;
    logic [31:0] a;
    logic        w;
    ce = 0; we = 0; addr = 0; wdata = 0; sel = 0;
    ce0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; sel0 = 0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_data", rdata, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ack_w0", 32'(ack0), 32'd0);
    rst = 0;
    @(negedge clk);

    // RAM write/read
    txn(1, 32'h40, 32'hDEADBEEF, 16'h0001);
    txn(0, 32'h40, 32'h0, 16'h0001);
    // device registers
    txn(0, 32'h0, 32'h0, 16'h0002);
    txn(1, 32'h4, 32'h12345678, 16'h0002);
    txn(0, 32'h4, 32'h0, 16'h0002);
    txn(1, 32'h0, 32'hFFFFFFFF, 16'h0002);  // ID is read-only
    txn(0, 32'h0, 32'h0, 16'h0002);
    txn(0, 32'h8, 32'h0, 16'h0002);          // access counter
    // unmapped accesses and status clear
    txn(1, 32'h40, 32'h55555555, 16'h0004);
    txn(0, 32'h40, 32'h0, 16'h0003);
    txn(0, 32'hC, 32'h0, 16'h0002);
    txn(1, 32'hC, 32'h1, 16'h0002);
    txn(0, 32'h40, 32'h0, 16'h0001);         // unmapped write left RAM alone
    // counter clear then read
    txn(1, 32'h8, 32'h77, 16'h0002);
    txn(0, 32'h8, 32'h0, 16'h0002);
    // aliasing
    txn(1, 32'h1000, 32'hA5A5A5A5, 16'h0001);
    txn(0, 32'h0000, 32'h0, 16'h0001);
    txn(0, 32'h0043, 32'h0, 16'h0001);

    // reset during WAIT of a RAM write
    txn(1, 32'h80, 32'h0BADF00D, 16'h0001);
    txn(1, 32'h12345, 32'h0, 16'hFFFF);      // raise err before reset
    ce = 1; we = 1; addr = 32'h80; wdata = 32'h11111111; sel = 16'h0001;
    @(posedge clk);
    #1 ce = 0; sel = 0;
    @(negedge clk);
    rst = 1;
    #1;
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_data", rdata, 32'h0);
    chk("midrst_err", 32'(err), 32'd0);
    @(negedge clk);
    chk("midrst_ack2", 32'(ack), 32'd0);
    rst = 0;
    m_scratch = 0; m_cnt = 0; m_err = 0; m_last = 0;
    @(negedge clk);
    txn(0, 32'h80, 32'h0, 16'h0001);
    txn(0, 32'h8, 32'h0, 16'h0002);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      w = $urandom_range(0, 1);
      a = $urandom;
      if (r < 5) begin
        s = 16'h0001;
        if (!w) a = written[$urandom_range(0, written.size() - 1)] ^ 32'($urandom_range(0, 3));
      end else if (r < 8) s = 16'h0002;
      else begin
        s = 16'($urandom);
        if (s == 16'h0000 || s == 16'h0001 || s == 16'h0002) s = 16'h8001;
      end
      txn(w, a, $urandom, s);
    end

    // zero-wait DUT: request held on the bus continuously
    ce0 = 1; we0 = 0; addr0 = 32'h0; sel0 = 16'h0002;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("w0_ack_pattern", 32'(ack0), (i % 3 == 0) ? 32'd1 : 32'd0);
      if (i % 3 == 0) chk("w0_data", rdata0, DEV_ID);
    end
    ce0 = 0; sel0 = 0;
    repeat (3) @(negedge clk);
    chk("w0_idle", 32'(ack0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
